rsp_byte_fifo: RTL and testbench
================================

Name: rsp_byte_fifo

Overview:
- Buffers response bytes between the FPGA command/response controller (fcr_ctrl) and the RS232 serializer (rs232_ser).
- Input side: fcr_ctrl req/ack byte handshake. Output side: first-word-fall-through FIFO read interface, wired directly to rs232_ser tx_fifo_*.
- Replaces the single-register rsp_byte_data_reg adapter, so fcr_ctrl can emit multi-byte responses without stalling on every serialized byte.

Parameters:
P_WIDTH, 8, data width in bits.
P_DEPTH_LOG2, 4, log2 of storage depth (default 16 entries).

Ports:
clk  input  1  system clock (50 MHz).
rst  input  1  reset, asynchronous, active-high.
byte_req  input  1  upstream request; byte_data valid while high.
byte_data  input  P_WIDTH  upstream byte.
byte_ack  output  1  one-cycle pulse; byte_data accepted this cycle.
tx_fifo_rd_en  input  1  pop from serializer.
tx_fifo_data  output  P_WIDTH  head entry; valid while tx_fifo_empty is low.
tx_fifo_empty  output  1  no entries stored.
fifo_full  output  1  count equals 2^P_DEPTH_LOG2.
fifo_level  output  P_DEPTH_LOG2+1  current entry count.

Behaviour:
- Reset, asynchronous, active-high. While rst is high:
  - Pointers and count are 0; byte_ack=0; tx_fifo_empty=1; fifo_full=0; fifo_level=0.
  - Storage contents are don't-care. tx_fifo_data reads the memory at rd_ptr (undefined after reset); the bench must not check it while empty.
- Storage: 2^P_DEPTH_LOG2 x P_WIDTH memory; wr_ptr and rd_ptr are P_DEPTH_LOG2 bits wide and wrap modulo depth; count is P_DEPTH_LOG2+1 bits.
- Accept rule, evaluated each cycle on registered state: accept = byte_req & !fifo_full & !byte_ack_q, where byte_ack_q is the registered byte_ack.
  - On accept: byte_ack goes high the next cycle.
  - In that same ack cycle: mem[wr_ptr] <= byte_data, wr_ptr increments.
- Throughput: the ack-gap rule gives one byte per 2 cycles maximum. The requester has one cycle after ack to drop or update req/data.
- Requester contract: hold byte_req and byte_data stable until byte_ack. The block captures byte_data on the ack cycle.
- Full: fifo_full is taken from registered count. A read in the same cycle does not enable acceptance; acceptance resumes the cycle after count drops.
- Read side (FWFT): tx_fifo_data = mem[rd_ptr] with a combinational read of registered storage.
  - tx_fifo_rd_en & !tx_fifo_empty: rd_ptr increments.
  - tx_fifo_rd_en while empty: ignored; no pointer or count change.
- Count update per cycle:
  - +1 on write only; -1 on valid read only.
  - Unchanged when both occur or neither occurs.
- Simultaneous write and read at count=1: count stays 1, head advances to the new byte, tx_fifo_empty stays 0.
- Flags tx_fifo_empty, fifo_full and fifo_level are registered, derived from the next count value. They update on the same edge as the pointers.
- Write latency: from the ack cycle, tx_fifo_empty deasserts and data is visible on the following cycle.
- Reset mid-transfer: all queued bytes are discarded and byte_ack drops immediately. A held byte_req is re-accepted after rst releases (first ack 2 cycles after release).
- Overflow and underflow are impossible by construction. No error outputs.

Test Plan:
1. Reset, then byte_req held with byte_data=0xA5.
   -> byte_ack pulses once.
   -> Next cycle: tx_fifo_empty=0, tx_fifo_data=0xA5, fifo_level=1.
   -> Single rd_en pulse returns empty=1, level=0.
2. Burst of 16 bytes 0x00..0x0F, rd_en held low.
   -> 16 ack pulses, each separated by at least one low cycle.
   -> fifo_full=1, level=16; 17th byte_req gets no ack.
   -> One rd_en pops 0x00; the 17th byte (0x10) is acked within 2 cycles after full deasserts.
3. Continuous writes with rd_en asserted whenever not empty, 40 bytes 0x30..0x57.
   -> Output order exactly 0x30..0x57, wrapping both pointers twice.
   -> fifo_level never exceeds 2.
4. Level=1 with head 0x11; write 0x22 and rd_en on the same cycle.
   -> Level stays 1, tx_fifo_data=0x22, empty never asserts.
5. rd_en pulses while empty after reset.
   -> Level stays 0, rd_ptr unchanged.
   -> Next write of 0x7E is read back as 0x7E.
6. Level=5, byte_req high; assert rst for 1 cycle.
   -> Immediately: empty=1, level=0, byte_ack=0.
   -> Pending byte acked 2 cycles after rst deasserts.

Source files
------------

// File: rtl/rsp_byte_fifo.sv
// Response byte FIFO between fcr_ctrl (req/ack byte handshake) and rs232_ser
// (first-word-fall-through read port). Registered flags, one accept per two cycles.
module rsp_byte_fifo #(
  parameter int P_WIDTH      = 8,
  parameter int P_DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  byte_req,
  input  logic [P_WIDTH-1:0]    byte_data,
  output logic                  byte_ack,
  input  logic                  tx_fifo_rd_en,
  output logic [P_WIDTH-1:0]    tx_fifo_data,
  output logic                  tx_fifo_empty,
  output logic                  fifo_full,
  output logic [P_DEPTH_LOG2:0] fifo_level
);

  localparam int DEPTH = 1 << P_DEPTH_LOG2;
  localparam logic [P_DEPTH_LOG2:0] FULL_COUNT = (P_DEPTH_LOG2 + 1)'(DEPTH);

  logic [P_WIDTH-1:0]      mem [DEPTH];
  logic [P_DEPTH_LOG2-1:0] wr_ptr_q;
  logic [P_DEPTH_LOG2-1:0] rd_ptr_q;
  logic [P_DEPTH_LOG2:0]   count_q;
  logic [P_DEPTH_LOG2:0]   count_next;
  logic                    ack_q;
  logic                    empty_q;
  logic                    full_q;
  logic                    accept;
  logic                    wr_en;
  logic                    rd_en;

  // The ack register doubles as the write strobe: data is captured on the ack cycle,
  // and blocking acceptance while it is high spaces acks at least one cycle apart.
  assign accept = byte_req & ~full_q & ~ack_q;
  assign wr_en  = ack_q;
  assign rd_en  = tx_fifo_rd_en & ~empty_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    count_next = count_q;
    if (wr_en && !rd_en) begin
      count_next = count_q + 1'b1;
    end else if (!wr_en && rd_en) begin
      count_next = count_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ack_q    <= 1'b0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      ack_q   <= accept;
      count_q <= count_next;
      empty_q <= (count_next == '0);
      full_q  <= (count_next == FULL_COUNT);
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // NOTE: storage has no reset; stale contents are unreachable because the count gates reads.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= byte_data;
    end
  end

  assign byte_ack      = ack_q;
  assign tx_fifo_data  = mem[rd_ptr_q];
  assign tx_fifo_empty = empty_q;
  assign fifo_full     = full_q;
  assign fifo_level    = count_q;

endmodule

// File: tb/tb_rsp_byte_fifo.sv
// Self-checking bench for rsp_byte_fifo: directed table, handshake corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_rsp_byte_fifo;

  localparam int W     = 8;
  localparam int LOG2  = 4;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst;
  logic          byte_req;
  logic [W-1:0]  byte_data;
  logic          byte_ack;
  logic          tx_fifo_rd_en;
  logic [W-1:0]  tx_fifo_data;
  logic          tx_fifo_empty;
  logic          fifo_full;
  logic [LOG2:0] fifo_level;

  rsp_byte_fifo #(.P_WIDTH(W), .P_DEPTH_LOG2(LOG2)) dut (
    .clk           (clk),
    .rst           (rst),
    .byte_req      (byte_req),
    .byte_data     (byte_data),
    .byte_ack      (byte_ack),
    .tx_fifo_rd_en (tx_fifo_rd_en),
    .tx_fifo_data  (tx_fifo_data),
    .tx_fifo_empty (tx_fifo_empty),
    .fifo_full     (fifo_full),
    .fifo_level    (fifo_level)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: contents as a queue plus the pending-ack bit.
  logic [W-1:0] m_q[$];
  logic         m_ack = 1'b0;
  logic [W-1:0] out_q[$];
  int           max_level = 0;

  typedef struct {
    logic         req;
    logic [W-1:0] data;
    logic         rd;
    logic         ack;
    logic         empty;
    int           level;
    logic         chk_data;
    logic [W-1:0] q;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs at negedge, update model at posedge, compare after it.
  task automatic step(input logic req, input logic [W-1:0] d, input logic rd);
    logic         rd_ok;
    logic         acc;
    logic [W-1:0] head;
    byte_req      = req;
    byte_data     = d;
    tx_fifo_rd_en = rd;
    head = tx_fifo_data;
    @(posedge clk);
    rd_ok = rd && (m_q.size() != 0);
    acc   = req && (m_q.size() != DEPTH) && !m_ack;
    if (rd_ok) begin
      out_q.push_back(head);
      void'(m_q.pop_front());
    end
    if (m_ack) m_q.push_back(d);
    m_ack = acc;
    #1;
    check("ack", 32'(byte_ack), 32'(m_ack));
    check("empty", 32'(tx_fifo_empty), 32'(m_q.size() == 0));
    check("full", 32'(fifo_full), 32'(m_q.size() == DEPTH));
    check("level", 32'(fifo_level), 32'(m_q.size()));
    if (m_q.size() != 0) check("data", 32'(tx_fifo_data), 32'(m_q[0]));
    if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_ack", 32'(byte_ack), 32'd0);
    check("rst_empty", 32'(tx_fifo_empty), 32'd1);
    check("rst_full", 32'(fifo_full), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_q.delete();
    m_ack = 1'b0;
  endtask

  // Present one byte, wait (bounded) for its ack, then hold data through the ack cycle.
  task automatic send(input logic [W-1:0] d, input logic auto_rd, input logic ack_rd,
                      output int lat);
    lat = 0;
    while (byte_ack !== 1'b1 && lat < 40) begin
      step(1'b1, d, auto_rd && (m_q.size() != 0));
      lat++;
    end
    if (byte_ack !== 1'b1) begin
      check("ack_timeout", 32'(byte_ack), 32'd1);
    end else begin
      step(1'b0, d, ack_rd || (auto_rd && (m_q.size() != 0)));
    end
  endtask

  initial begin
    int lat;
    int acks;
    logic         r_req;
    logic [W-1:0] r_data;
    logic         drop_next;

    rst = 1'b1;
    byte_req = 1'b0;
    byte_data = '0;
    tx_fifo_rd_en = 1'b0;
    @(negedge clk);
    do_reset();

    // Single byte round trip, then reads while empty and a write that follows them.
    tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 0, 1'b0, 8'h00};
    tbl[1] = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'hA5};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 0, 1'b0, 8'h00};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 0, 1'b0, 8'h00};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 0, 1'b0, 8'h00};
    tbl[5] = '{1'b1, 8'h7E, 1'b1, 1'b1, 1'b1, 0, 1'b0, 8'h00};
    tbl[6] = '{1'b0, 8'h7E, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'h7E};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'h7E};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 0, 1'b0, 8'h00};
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].req, tbl[i].data, tbl[i].rd);
      check($sformatf("tbl%0d_ack", i), 32'(byte_ack), 32'(tbl[i].ack));
      check($sformatf("tbl%0d_empty", i), 32'(tx_fifo_empty), 32'(tbl[i].empty));
      check($sformatf("tbl%0d_level", i), 32'(fifo_level), 32'(tbl[i].level));
      if (tbl[i].chk_data) check($sformatf("tbl%0d_data", i), 32'(tx_fifo_data), 32'(tbl[i].q));
    end

    // Fill to full, confirm the 17th byte stalls, then resumes after one pop.
    do_reset();
    for (int i = 0; i < 16; i++) send(W'(i), 1'b0, 1'b0, lat);
    check("burst_full", 32'(fifo_full), 32'd1);
    check("burst_level", 32'(fifo_level), 32'd16);
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'h10, 1'b0);
      if (byte_ack) acks++;
    end
    check("full_no_ack", 32'(acks), 32'd0);
    check("full_head", 32'(tx_fifo_data), 32'h00);
    step(1'b1, 8'h10, 1'b1);
    check("pop_full", 32'(fifo_full), 32'd0);
    send(8'h10, 1'b0, 1'b0, lat);
    check("resume_lat_ok", 32'(lat <= 2), 32'd1);
    check("refull_level", 32'(fifo_level), 32'd16);

    // Streaming: 40 bytes with reads whenever data is present.
    do_reset();
    out_q.delete();
    max_level = 0;
    for (int i = 0; i < 40; i++) send(8'h30 + W'(i), 1'b1, 1'b0, lat);
    for (int i = 0; i < 10 && m_q.size() != 0; i++) step(1'b0, 8'h00, 1'b1);
    check("stream_count", 32'(out_q.size()), 32'd40);
    for (int i = 0; i < out_q.size() && i < 40; i++)
      check($sformatf("stream_%0d", i), 32'(out_q[i]), 32'(8'h30 + i));
    check("stream_maxlvl_ok", 32'(max_level <= 2), 32'd1);

    // Simultaneous write and read at level 1.
    do_reset();
    send(8'h11, 1'b0, 1'b0, lat);
    check("l1_head", 32'(tx_fifo_data), 32'h11);
    send(8'h22, 1'b0, 1'b1, lat);
    check("wr_rd_level", 32'(fifo_level), 32'd1);
    check("wr_rd_data", 32'(tx_fifo_data), 32'h22);
    check("wr_rd_empty", 32'(tx_fifo_empty), 32'd0);

    // Reset mid-transfer with a byte pending.
    do_reset();
    for (int i = 0; i < 5; i++) send(8'h50 + W'(i), 1'b0, 1'b0, lat);
    check("pre_rst_level", 32'(fifo_level), 32'd5);
    step(1'b1, 8'h66, 1'b0);
    do_reset();
    send(8'h66, 1'b0, 1'b0, lat);
    check("post_rst_lat_ok", 32'((lat >= 1) && (lat <= 2)), 32'd1);
    check("post_rst_level", 32'(fifo_level), 32'd1);
    check("post_rst_data", 32'(tx_fifo_data), 32'h66);

    // Random traffic under contract-obeying requester, varying read pressure.
    r_req = 1'b0;
    r_data = '0;
    drop_next = 1'b0;
    for (int i = 0; i < 2400; i++) begin
      int rd_pct;
      rd_pct = (i / 600 == 0) ? 10 : (i / 600 == 1) ? 90 : (i / 600 == 2) ? 50 : 0;
      if (drop_next) begin
        drop_next = 1'b0;
        r_req = ($urandom_range(0, 1) == 1);
        r_data = W'($urandom_range(0, 255));
      end else if (m_ack) begin
        drop_next = 1'b1;
      end else if (!r_req && $urandom_range(0, 2) != 0) begin
        r_req = 1'b1;
        r_data = W'($urandom_range(0, 255));
      end
      step(r_req, r_data, ($urandom_range(0, 99) < rd_pct));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
